// File: rtl/ysyx_25080202_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25080202_pkg
// Shared types and constants for the IFU/LSU memory arbiter.
//   arb_state_e      : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_e          : which master owns the outstanding transaction
//   SIZE_*           : access size encodings carried on io_*_size
//   DEFAULT_ERR_DATA : read data returned when the memory side times out
// ---------------------------------------------------------------------------
package ysyx_25080202_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hdeadbeef;

endpackage

// File: rtl/ysyx_25080202_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_25080202_mem_arbiter_if
// Bundles every handshake/bus signal around the arbiter.
//   io_ifu_* : fetch master request (reqValid, addr) and response (respValid, rdata)
//   io_lsu_* : load/store master request (reqValid, addr, wdata, wen, wmask, size)
//              and response (respValid, rdata)
//   io_mem_* : shared memory port, issue pulse + latched payload out,
//              response pulse + read data in
//   io_busy / io_timeout : arbiter status
// Modports:
//   slave  : the arbiter's view (takes master requests, drives the memory port)
//   master : the surrounding environment (requesters plus memory side)
// ---------------------------------------------------------------------------
interface ysyx_25080202_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              io_ifu_reqValid;
  logic [ADDR_W-1:0] io_ifu_addr;
  logic              io_ifu_respValid;
  logic [DATA_W-1:0] io_ifu_rdata;

  logic              io_lsu_reqValid;
  logic [ADDR_W-1:0] io_lsu_addr;
  logic [DATA_W-1:0] io_lsu_wdata;
  logic              io_lsu_wen;
  logic [3:0]        io_lsu_wmask;
  logic [1:0]        io_lsu_size;
  logic              io_lsu_respValid;
  logic [DATA_W-1:0] io_lsu_rdata;

  logic              io_mem_reqValid;
  logic [ADDR_W-1:0] io_mem_addr;
  logic              io_mem_wen;
  logic [DATA_W-1:0] io_mem_wdata;
  logic [3:0]        io_mem_wmask;
  logic [1:0]        io_mem_size;
  logic              io_mem_respValid;
  logic [DATA_W-1:0] io_mem_rdata;

  logic              io_busy;
  logic              io_timeout;

  modport slave (
    input  io_ifu_reqValid, io_ifu_addr,
    output io_ifu_respValid, io_ifu_rdata,
    input  io_lsu_reqValid, io_lsu_addr, io_lsu_wdata, io_lsu_wen, io_lsu_wmask, io_lsu_size,
    output io_lsu_respValid, io_lsu_rdata,
    output io_mem_reqValid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask, io_mem_size,
    input  io_mem_respValid, io_mem_rdata,
    output io_busy, io_timeout
  );

  modport master (
    output io_ifu_reqValid, io_ifu_addr,
    input  io_ifu_respValid, io_ifu_rdata,
    output io_lsu_reqValid, io_lsu_addr, io_lsu_wdata, io_lsu_wen, io_lsu_wmask, io_lsu_size,
    input  io_lsu_respValid, io_lsu_rdata,
    input  io_mem_reqValid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask, io_mem_size,
    output io_mem_respValid, io_mem_rdata,
    input  io_busy, io_timeout
  );

endinterface

// File: rtl/ysyx_25080202_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25080202_mem_arbiter
// Shares one memory/MMIO request port between the IFU and the LSU. One
// transaction is outstanding at a time; simultaneous requests are granted
// round-robin, and a memory side that never answers is cut off after
// TIMEOUT_CYCLES with an ERR_DATA response.
// Ports:
//   clock   : rising-edge clock for all state
//   reset_n : asynchronous active-low reset
//   bus     : ysyx_25080202_mem_arbiter_if.slave (IFU, LSU and memory ports,
//             io_busy, io_timeout)
// ---------------------------------------------------------------------------
module ysyx_25080202_mem_arbiter
  import ysyx_25080202_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEFAULT_ERR_DATA)
) (
  input logic                        clock,
  input logic                        reset_n,
  ysyx_25080202_mem_arbiter_if.slave bus
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e        state_q;
  owner_e            owner_q;
  owner_e            lastGrant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [1:0]        size_q;
  logic              memReqValid_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  cnt_d;
  owner_e            grant_d;
  logic              anyReq;
  logic              timeoutHit;
  logic              respFire;
  logic [DATA_W-1:0] respData;

  // Round-robin pick: a tie goes to whoever did not win last time; a lone
  // requester always wins. Only meaningful when at least one request is up.
  function automatic owner_e pickOwner(input logic ifuReq, input logic lsuReq,
                                       input owner_e lastGrant);
    owner_e pick;
    if (ifuReq && lsuReq) begin
      pick = (lastGrant == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
    end else if (lsuReq) begin
      pick = OWNER_LSU;
    end else begin
      pick = OWNER_IFU;
    end
    return pick;
  endfunction

  assign anyReq  = bus.io_ifu_reqValid | bus.io_lsu_reqValid;
  assign grant_d = pickOwner(bus.io_ifu_reqValid, bus.io_lsu_reqValid, lastGrant_q);

  // cnt_d is the number of WAIT cycles including the current one, so the
  // error response lands exactly TIMEOUT_CYCLES cycles after ISSUE.
  assign cnt_d      = cnt_q + 1'b1;
  assign timeoutHit = (state_q == ST_WAIT) && !bus.io_mem_respValid && (cnt_d == CNT_LIMIT);
  assign respFire   = (state_q == ST_WAIT) && (bus.io_mem_respValid || timeoutHit);
  assign respData   = bus.io_mem_respValid ? bus.io_mem_rdata : ERR_DATA;

  // Responses are combinational so the owner sees the memory data in the
  // same cycle it arrives; rdata is forced to zero whenever not responding.
  assign bus.io_ifu_respValid = respFire && (owner_q == OWNER_IFU);
  assign bus.io_lsu_respValid = respFire && (owner_q == OWNER_LSU);
  assign bus.io_ifu_rdata     = bus.io_ifu_respValid ? respData : '0;
  assign bus.io_lsu_rdata     = bus.io_lsu_respValid ? respData : '0;
  assign bus.io_timeout       = timeoutHit;

  assign bus.io_mem_reqValid = memReqValid_q;
  assign bus.io_mem_addr     = addr_q;
  assign bus.io_mem_wen      = wen_q;
  assign bus.io_mem_wdata    = wdata_q;
  assign bus.io_mem_wmask    = wmask_q;
  assign bus.io_mem_size     = size_q;
  assign bus.io_busy         = busy_q;

  // Arbiter FSM. The payload latch is only written on a grant, so later
  // requester changes cannot reach the memory port and the last payload
  // stays visible until the next grant. memReqValid_q and busy_q are
  // registered alongside the state so they track ISSUE / not-IDLE exactly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWNER_IFU;
      lastGrant_q   <= OWNER_IFU;
      addr_q        <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= 4'b0000;
      size_q        <= 2'b00;
      memReqValid_q <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      memReqValid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (anyReq) begin
            owner_q       <= grant_d;
            lastGrant_q   <= grant_d;
            state_q       <= ST_ISSUE;
            memReqValid_q <= 1'b1;
            busy_q        <= 1'b1;
            if (grant_d == OWNER_LSU) begin
              addr_q  <= bus.io_lsu_addr;
              wen_q   <= bus.io_lsu_wen;
              wdata_q <= bus.io_lsu_wdata;
              wmask_q <= bus.io_lsu_wmask;
              size_q  <= bus.io_lsu_size;
            end else begin
              addr_q  <= bus.io_ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= 4'b0000;
              size_q  <= SIZE_WORD;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (respFire) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25080202_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25080202_mem_arbiter
// Scoreboard bench: each request is queued for its master driver while the
// expected memory-side payload and the expected response are pushed into
// scoreboard queues; a memory model pops and compares them as the DUT
// produces mem requests and responses.
// ---------------------------------------------------------------------------
module tb_ysyx_25080202_mem_arbiter;
  import ysyx_25080202_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
  } memReq_t;

  typedef struct {
    memReq_t pay;
    int      cyc;
  } expMem_t;

  typedef struct {
    logic        isLsu;
    logic [31:0] rdata;
    logic        timeout;
    int          cyc;
  } expResp_t;

  typedef struct {
    memReq_t pay;
    logic    scramble;
  } masterReq_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cycleCount = 0;

  logic abortAll = 1'b0;
  logic memSilent = 1'b0;
  logic forceStray = 1'b0;
  int   memLatency = 1;

  int errorCount = 0;
  int checkCount = 0;

  expMem_t    expMemQ[$];
  expResp_t   expRespQ[$];
  masterReq_t ifuQ[$];
  masterReq_t lsuQ[$];

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  ysyx_25080202_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_25080202_mem_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(TIMEOUT),
    .ERR_DATA      (32'hdeadbeef)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Memory contents as the bench sees them: the fetch target of the first
  // test holds an ebreak, everything else is a fixed scramble of the address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    logic [31:0] d;
    if (a == 32'h3000_0000) d = 32'h0010_0073;
    else                    d = a ^ 32'h5a5a_5a5a;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Queue one request for a master and record what the memory side and the
  // master should see for it. Calls must be made in expected grant order.
  task automatic applyStimulus(input logic isLsu, input logic [31:0] addr,
                               input logic wen, input logic [31:0] wdata,
                               input logic [3:0] wmask, input logic [1:0] size,
                               input logic scramble, input logic expectResp,
                               input logic expTimeout, input int memCyc,
                               input int respCyc);
    masterReq_t mr;
    expMem_t    em;
    expResp_t   er;
    mr.pay.addr = addr;
    mr.scramble = scramble;
    if (isLsu) begin
      mr.pay.wen   = wen;
      mr.pay.wdata = wdata;
      mr.pay.wmask = wmask;
      mr.pay.size  = size;
    end else begin
      mr.pay.wen   = 1'b0;
      mr.pay.wdata = 32'h0;
      mr.pay.wmask = 4'h0;
      mr.pay.size  = 2'b10;
    end
    em.pay = mr.pay;
    em.cyc = memCyc;
    expMemQ.push_back(em);
    if (expectResp) begin
      er.isLsu   = isLsu;
      er.rdata   = expTimeout ? 32'hdeadbeef : memData(addr);
      er.timeout = expTimeout;
      er.cyc     = respCyc;
      expRespQ.push_back(er);
    end
    if (isLsu) lsuQ.push_back(mr);
    else       ifuQ.push_back(mr);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((expRespQ.size() != 0 || expMemQ.size() != 0 || ifuQ.size() != 0 ||
            lsuQ.size() != 0 || bus.io_busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drainResp", expRespQ.size(), 0);
    checkOutput("drainMem", expMemQ.size(), 0);
    repeat (2) @(negedge clock);
    #1;
  endtask

  // Memory model and scoreboard consumer: samples at negedge, drives the
  // response just after the following posedge.
  initial begin : memModel
    int          memCnt;
    logic [31:0] memAddr;
    memReq_t     seen;
    expMem_t     em;
    expResp_t    er;
    memCnt = 0;
    memAddr = 32'h0;
    bus.io_mem_respValid = 1'b0;
    bus.io_mem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        memCnt = 0;
        memAddr = 32'h0;
      end else begin
        if (!bus.io_ifu_respValid) checkOutput("ifuRdataQuiet", bus.io_ifu_rdata, 0);
        if (!bus.io_lsu_respValid) checkOutput("lsuRdataQuiet", bus.io_lsu_rdata, 0);
        checkOutput("respExclusive", bus.io_ifu_respValid & bus.io_lsu_respValid, 0);
        if (bus.io_mem_reqValid) begin
          seen.addr  = bus.io_mem_addr;
          seen.wen   = bus.io_mem_wen;
          seen.wdata = bus.io_mem_wdata;
          seen.wmask = bus.io_mem_wmask;
          seen.size  = bus.io_mem_size;
          if (expMemQ.size() == 0) begin
            checkOutput("unexpectedMemReq", bus.io_mem_reqValid, 0);
          end else begin
            em = expMemQ.pop_front();
            checkOutput("memPayload", seen, em.pay);
            if (em.cyc >= 0) checkOutput("memReqCycle", cycleCount, em.cyc);
          end
          memAddr = bus.io_mem_addr;
          memCnt = memLatency;
        end else begin
          checkOutput("memAddrHold", bus.io_mem_addr, memAddr);
        end
        if (bus.io_ifu_respValid || bus.io_lsu_respValid) begin
          if (expRespQ.size() == 0) begin
            checkOutput("unexpectedResp", {bus.io_ifu_respValid, bus.io_lsu_respValid}, 0);
          end else begin
            er = expRespQ.pop_front();
            checkOutput("respOwner", bus.io_lsu_respValid, er.isLsu);
            checkOutput("respRdata", bus.io_lsu_respValid ? bus.io_lsu_rdata : bus.io_ifu_rdata,
                        er.rdata);
            checkOutput("respTimeout", bus.io_timeout, er.timeout);
            if (er.cyc >= 0) checkOutput("respCycle", cycleCount, er.cyc);
          end
        end else if (bus.io_timeout) begin
          checkOutput("strayTimeout", bus.io_timeout, 0);
        end
      end
      @(posedge clock);
      #1;
      bus.io_mem_respValid = 1'b0;
      bus.io_mem_rdata = 32'h0;
      if (forceStray) begin
        bus.io_mem_respValid = 1'b1;
        bus.io_mem_rdata = 32'hbad0_bad0;
      end else if (memCnt > 0) begin
        memCnt--;
        if (memCnt == 0 && !memSilent) begin
          bus.io_mem_respValid = 1'b1;
          bus.io_mem_rdata = memData(memAddr);
        end
      end
    end
  end

  // IFU master: holds reqValid until its response, then immediately offers
  // the next queued request (back-to-back) or drops.
  initial begin : ifuDriver
    logic       active;
    logic       done;
    masterReq_t r;
    active = 1'b0;
    bus.io_ifu_reqValid = 1'b0;
    bus.io_ifu_addr = 32'h0;
    forever begin
      @(negedge clock);
      done = bus.io_ifu_respValid;
      @(posedge clock);
      #1;
      if (abortAll) begin
        active = 1'b0;
        bus.io_ifu_reqValid = 1'b0;
      end else if (!active || done) begin
        if (ifuQ.size() > 0) begin
          r = ifuQ.pop_front();
          bus.io_ifu_addr = r.pay.addr;
          bus.io_ifu_reqValid = 1'b1;
          active = 1'b1;
        end else begin
          bus.io_ifu_reqValid = 1'b0;
          active = 1'b0;
        end
      end
    end
  end

  // LSU master: same protocol; a scrambling request overwrites its payload
  // with garbage once the arbiter has taken it.
  initial begin : lsuDriver
    logic       active;
    logic       done;
    logic       granted;
    masterReq_t r;
    active = 1'b0;
    r = '{pay: '0, scramble: 1'b0};
    bus.io_lsu_reqValid = 1'b0;
    bus.io_lsu_addr = 32'h0;
    bus.io_lsu_wdata = 32'h0;
    bus.io_lsu_wen = 1'b0;
    bus.io_lsu_wmask = 4'h0;
    bus.io_lsu_size = 2'b00;
    forever begin
      @(negedge clock);
      done = bus.io_lsu_respValid;
      granted = bus.io_busy;
      @(posedge clock);
      #1;
      if (abortAll) begin
        active = 1'b0;
        bus.io_lsu_reqValid = 1'b0;
      end else if (!active || done) begin
        if (lsuQ.size() > 0) begin
          r = lsuQ.pop_front();
          bus.io_lsu_addr = r.pay.addr;
          bus.io_lsu_wdata = r.pay.wdata;
          bus.io_lsu_wen = r.pay.wen;
          bus.io_lsu_wmask = r.pay.wmask;
          bus.io_lsu_size = r.pay.size;
          bus.io_lsu_reqValid = 1'b1;
          active = 1'b1;
        end else begin
          bus.io_lsu_reqValid = 1'b0;
          active = 1'b0;
        end
      end else if (r.scramble && granted) begin
        bus.io_lsu_addr = 32'hffff_fff0;
        bus.io_lsu_wdata = 32'hcafe_f00d;
        bus.io_lsu_wen = 1'b0;
        bus.io_lsu_wmask = 4'hf;
        bus.io_lsu_size = 2'b01;
      end
    end
  end

  initial begin : mainSeq
    int c;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rstBusy", bus.io_busy, 0);
    checkOutput("rstMemReq", bus.io_mem_reqValid, 0);
    checkOutput("rstMemAddr", bus.io_mem_addr, 0);
    checkOutput("rstIfuResp", bus.io_ifu_respValid, 0);
    checkOutput("rstLsuResp", bus.io_lsu_respValid, 0);
    checkOutput("rstTimeout", bus.io_timeout, 0);
    reset_n = 1'b1;
    @(negedge clock);
    #1;

    $display("[TB] IFU alone with 1-cycle memory");
    c = cycleCount;
    applyStimulus(1'b0, 32'h3000_0000, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, c + 2, c + 3);
    waitDrain(50);

    $display("[TB] simultaneous IFU and LSU: LSU wins the first tie");
    c = cycleCount;
    applyStimulus(1'b1, 32'h2000_0004, 1'b0, 32'h0, 4'hf, 2'b10, 1'b0, 1'b1, 1'b0, c + 2, c + 3);
    applyStimulus(1'b0, 32'h3000_0010, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, c + 5, c + 6);
    waitDrain(50);

    $display("[TB] both held for 8 transactions: grants alternate");
    c = cycleCount;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        applyStimulus(1'b1, 32'h2000_0100 + 32'(k * 4), 1'(k % 4 == 0), 32'h1111_0000 + 32'(k),
                      4'(k + 3), 2'(k % 3), 1'b0, 1'b1, 1'b0, c + 2 + 3 * k, c + 3 + 3 * k);
      else
        applyStimulus(1'b0, 32'h3000_0200 + 32'(k * 4), 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b1,
                      1'b0, c + 2 + 3 * k, c + 3 + 3 * k);
    end
    waitDrain(100);

    $display("[TB] LSU store with payload scrambled while waiting");
    memLatency = 3;
    c = cycleCount;
    applyStimulus(1'b1, 32'h1000_0000, 1'b1, 32'h0000_0041, 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0,
                  c + 2, c + 5);
    waitDrain(50);
    memLatency = 1;

    $display("[TB] silent memory: timeout response");
    memSilent = 1'b1;
    c = cycleCount;
    applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1,
                  c + 2, c + 2 + TIMEOUT);
    waitDrain(80);
    checkOutput("idleAfterTimeout", bus.io_busy, 0);
    memSilent = 1'b0;

    $display("[TB] reset during WAIT, then a stray memory response");
    memSilent = 1'b1;
    c = cycleCount;
    applyStimulus(1'b0, 32'h3000_0020, 1'b0, 32'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, c + 2, -1);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("busyInWait", bus.io_busy, 1);
    reset_n = 1'b0;
    abortAll = 1'b1;
    #1;
    checkOutput("abortBusy", bus.io_busy, 0);
    checkOutput("abortIfuResp", bus.io_ifu_respValid, 0);
    checkOutput("abortMemReq", bus.io_mem_reqValid, 0);
    checkOutput("abortMemAddr", bus.io_mem_addr, 0);
    checkOutput("abortTimeout", bus.io_timeout, 0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    abortAll = 1'b0;
    memSilent = 1'b0;
    @(negedge clock);
    #1;
    forceStray = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("strayIgnored", {bus.io_ifu_respValid, bus.io_lsu_respValid}, 0);
    checkOutput("strayBusy", bus.io_busy, 0);
    forceStray = 1'b0;
    waitDrain(20);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ysyx_25080202_mem_arbiter.md
# ysyx_25080202_mem_arbiter

Two-into-one arbiter that shares a single memory/MMIO request port between the core's IFU (fetch) and LSU (load/store) masters. Sits between the CPU top-level `io_ifu_*` / `io_lsu_*` ports and the memory side, which is either the bench memory model or the SoC bus bridge. It keeps one transaction outstanding, grants round-robin on contention, and returns a response with `ERR_DATA` when the memory side times out.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 1024, maximum WAIT cycles before an error response; must be ≥1
- `ERR_DATA`, 32'hdeadbeef, rdata returned on timeout

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `io_ifu_reqValid`  in  1  fetch request, held until `io_ifu_respValid`
- `io_ifu_addr`  in  ADDR_W  fetch address
- `io_ifu_respValid`  out  1  one-cycle response pulse
- `io_ifu_rdata`  out  DATA_W  fetch data, valid with respValid
- `io_lsu_reqValid`  in  1  load/store request, held until `io_lsu_respValid`
- `io_lsu_addr`, `io_lsu_wdata`  in  ADDR_W/DATA_W  address, store data
- `io_lsu_wen`  in  1  store when 1
- `io_lsu_wmask`  in  4  byte enables
- `io_lsu_size`  in  2  00 byte, 01 half, 10 word
- `io_lsu_respValid`  out  1  one-cycle response pulse
- `io_lsu_rdata`  out  DATA_W  load data
- `io_mem_reqValid`  out  1  one-cycle issue pulse per transaction
- `io_mem_addr`, `io_mem_wen`, `io_mem_wdata`, `io_mem_wmask`, `io_mem_size`  out  ADDR_W/1/DATA_W/4/2  latched payload
- `io_mem_respValid`  in  1  memory response pulse
- `io_mem_rdata`  in  DATA_W  memory read data
- `io_busy`  out  1  FSM not IDLE
- `io_timeout`  out  1  one-cycle pulse when an error response is issued

## Operation
- FSM states: IDLE, ISSUE, WAIT. Registers: `owner` (IFU/LSU), `last_grant`, payload latch, timeout counter of width `$clog2(TIMEOUT_CYCLES+1)`.
- IDLE: if exactly one reqValid is high, grant it. If both are high, grant the master that is not `last_grant`. On the edge, latch the payload, set `owner` and `last_grant`, and go to ISSUE.
- An IFU grant latches `wen=0`, `wmask=0`, `size=2'b10`.
- ISSUE: `io_mem_reqValid`=1 for exactly this cycle; clear the counter; go to WAIT.
- WAIT: the counter increments each cycle. On `io_mem_respValid`, the owner's respValid=1 and rdata=`io_mem_rdata`, combinationally in the same cycle; go to IDLE.
- Else, when the counter equals `TIMEOUT_CYCLES`: the owner's respValid=1, rdata=`ERR_DATA`, `io_timeout`=1; go to IDLE.
- Non-owner respValid=0 and rdata=0 at all times. The owner's rdata is 0 whenever its respValid=0.
- `io_mem_respValid` is ignored in IDLE and ISSUE; stray responses are dropped. The memory side must not answer a transaction after it has timed out.
- `io_mem_*` payload outputs hold the latched values from ISSUE through IDLE, until the next grant.
- Requester payload changes after the grant have no effect.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `last_grant`=IFU, all outputs and latches 0. The first tie after reset goes to LSU.
- Reset mid-transaction aborts it: no respValid is ever issued for it.
- Latency: request high at edge N (IDLE) → `io_mem_reqValid` in cycle N+1 → with a 1-cycle memory, respValid in cycle N+2. Minimum request-to-request spacing is 3 cycles.
- Back-to-back: a master may keep reqValid high with a new payload in the cycle after its respValid. It is arbitrated normally in that IDLE cycle, so the other pending master wins the tie.
- A reqValid asserted while the FSM is busy waits; no request is lost, and no master starves (round-robin).
- Timeout: with no memory response, respValid occurs exactly `TIMEOUT_CYCLES` cycles after the ISSUE cycle.

## Structure
- Shared package `ysyx_25080202_pkg`: FSM state enum, owner enum (OWNER_IFU=0, OWNER_LSU=1), size encodings, default `ERR_DATA`.
- Single flat module; no sub-module needed. Round-robin select is a small combinational function local to the module.

## Test plan
- IFU alone, addr 0x30000000, memory returns 0x00100073 one cycle after issue → `io_mem_reqValid` in cycle N+1 with wen=0, size=10; `io_ifu_respValid` in N+2 with rdata 0x00100073; LSU outputs stay 0.
- IFU and LSU raised in the same cycle after reset → LSU granted first; IFU issued on the first IDLE cycle after LSU respValid.
- Both held continuously for 8 transactions → grants alternate LSU, IFU, LSU, …; exactly 4 responses each.
- LSU store, addr 0x10000000, wdata 0x41, wmask 0001, size 00, LSU payload changed to garbage during WAIT → memory sees the original payload; one `io_lsu_respValid`.
- Memory never responds, `TIMEOUT_CYCLES`=16 → `io_ifu_respValid` and `io_timeout` exactly 16 cycles after ISSUE, rdata 0xdeadbeef; FSM returns to IDLE.
- `reset_n` pulsed low during WAIT, then a late `io_mem_respValid` → all outputs 0 immediately; the stray response produces no respValid.
